// File: rtl/frame_uart_serializer.sv
// rtl/frame_uart_serializer.sv - streams a captured 64-sample frame to a byte UART
//
// Ports:
//   clk        system clock, everything on its rising edge
//   rst        synchronous active-high reset
//   inSignal   64 signed 18-bit samples, sample i at [18i+17:18i]
//   dataReady  frame-valid level; a rising edge starts a new frame
//   txBusy     UART transmitter busy flag
//   txData     byte for the UART, held from its txStart until the next txStart
//   txStart    one-cycle send request
//   busy       block is not idle
//   frameDone  one-cycle pulse after the final (checksum) byte completes
//   overrun    sticky: a frame edge arrived while a frame was in progress

module frame_uart_serializer (
  input  logic          clk,
  input  logic          rst,
  input  logic [1151:0] inSignal,
  input  logic          dataReady,
  input  logic          txBusy,
  output logic [7:0]    txData,
  output logic          txStart,
  output logic          busy,
  output logic          frameDone,
  output logic          overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam logic [7:0] LAST_BYTE   = 8'd193;

  state_t        state_q, state_d;
  logic [1151:0] buf_q, buf_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [5:0]    sample_idx_q, sample_idx_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          dRdyQ;
  logic          d_rdy_d;

  logic          rdy_edge;
  logic          is_data_byte;
  logic [10:0]   sample_base;
  logic [17:0]   cur_sample;
  logic [7:0]    cur_byte;

  // dRdyQ resets low, so a level already high right after reset is an edge.
  assign rdy_edge = dataReady & ~dRdyQ;

  // Bytes 1..192 carry sample data; byte 0 is the header, 193 the checksum.
  assign is_data_byte = (byte_cnt_q != 8'd0) && (byte_cnt_q != LAST_BYTE);

  // Sample select from the captured buffer only; inSignal is never read mid-frame.
  assign sample_base = 11'(sample_idx_q) * 11'd18;
  assign cur_sample  = buf_q[sample_base +: 18];

  always_comb begin
    cur_byte = 8'h00;
    if (byte_cnt_q == 8'd0) begin
      cur_byte = HEADER_BYTE;
    end else if (byte_cnt_q == LAST_BYTE) begin
      cur_byte = csum_q;
    end else begin
      // Each sample goes out as a sign-extended 24-bit value, MSB first.
      case (phase_q)
        2'd0:    cur_byte = {{6{cur_sample[17]}}, cur_sample[17:16]};
        2'd1:    cur_byte = cur_sample[15:8];
        default: cur_byte = cur_sample[7:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    byte_cnt_d   = byte_cnt_q;
    sample_idx_d = sample_idx_q;
    phase_d      = phase_q;
    csum_d       = csum_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    d_rdy_d      = dataReady;
    // Any edge outside IDLE drops that frame. This includes the cycle in
    // which WAIT_LO finishes the last byte, since the state is still WAIT_LO.
    overrun_d    = overrun_q | (rdy_edge && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (rdy_edge) begin
          buf_d        = inSignal;
          byte_cnt_d   = 8'd0;
          sample_idx_d = 6'd0;
          phase_d      = 2'd0;
          csum_d       = 8'h00;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (!txBusy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          if (is_data_byte) begin
            csum_d = csum_q ^ cur_byte;
          end
          state_d = WAIT_HI;
        end
      end

      WAIT_HI: begin
        // Wait for the UART to acknowledge the request by raising busy.
        if (txBusy) begin
          state_d = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (!txBusy) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (is_data_byte) begin
            // Phase/sample-index walk replaces a divide-by-3 of the byte count.
            if (phase_q == 2'd2) begin
              phase_d      = 2'd0;
              sample_idx_d = sample_idx_q + 6'd1;
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end
          if (byte_cnt_q == LAST_BYTE) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 8'd0;
      sample_idx_q <= 6'd0;
      phase_q      <= 2'd0;
      csum_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      dRdyQ        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      sample_idx_q <= sample_idx_d;
      phase_q      <= phase_d;
      csum_q       <= csum_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      dRdyQ        <= d_rdy_d;
    end
  end

  // Sample buffer carries no reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign txData    = tx_data_q;
  assign txStart   = tx_start_q;
  assign frameDone = frame_done_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/frame_uart_serializer.md
FRAME_UART_SERIALIZER -- requirements
Module: frame_uart_serializer

Interface
REQ-001 clk  input  1  Single system clock; all logic SHALL be clocked on posedge clk.
REQ-002 rst  input  1  Reset; SHALL be synchronous and active-high.
REQ-003 inSignal  input  1152  Filtered frame of 64 signed 18-bit samples; sample i SHALL be bits [18i+17:18i].
REQ-004 dataReady  input  1  Frame-valid level from the filter; a 0->1 transition SHALL mark a new frame.
REQ-005 txBusy  input  1  UART transmitter busy flag.
REQ-006 txData  output  8  Byte presented to the UART; SHALL be held stable from the txStart cycle until the next txStart.
REQ-007 txStart  output  1  One-cycle request to the UART to send txData.
REQ-008 busy  output  1  High whenever the block is not in IDLE.
REQ-009 frameDone  output  1  One-cycle pulse after the last byte of a frame completes.
REQ-010 overrun  output  1  Sticky flag: a frame was dropped.

Function
REQ-011 Edge detect: the block SHALL register dataReady in a register named dRdyQ, which resets to 0. edge = dataReady & ~dRdyQ, so dataReady high in the first cycle after reset SHALL count as an edge.
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-013 IDLE: on an edge, the block SHALL capture all 64 samples into an internal buffer in that cycle, clear the byte counter and checksum, and go to ISSUE.
REQ-014 ISSUE: when txBusy=0, the block SHALL drive txData, pulse txStart for exactly 1 cycle, and go to WAIT_HI. When txBusy=1, it SHALL stay in ISSUE with txStart=0.
REQ-015 WAIT_HI: the block SHALL stay until txBusy=1, then go to WAIT_LO.
REQ-016 WAIT_LO: when txBusy=0, the block SHALL advance the byte counter. If the finished byte was byte 193, it SHALL pulse frameDone in that cycle and go to IDLE; otherwise it SHALL go to ISSUE.
REQ-017 Frame byte order, 194 bytes total:
- byte 0: header 0xA5
- bytes 1..192: samples 0..63 in order, 3 bytes each, MSB first, each sample sign-extended to 24 bits
  - first byte = {6{s[17]}, s[17:16]}
  - second byte = s[15:8]
  - third byte = s[7:0]
- byte 193: checksum
REQ-018 Checksum SHALL be the XOR of bytes 1..192; the header SHALL NOT be included.
REQ-019 Byte selection SHALL use a sample index (0..63) and a phase counter (0..2); no divider SHALL be used.
REQ-020 The captured buffer SHALL be the only data source during a frame; changes on inSignal after capture SHALL have no effect.
REQ-021 An edge in any state other than IDLE SHALL be ignored (frame dropped) and SHALL set overrun=1. overrun SHALL clear only on rst.
REQ-022 An edge in the same cycle WAIT_LO returns to IDLE SHALL be dropped and SHALL set overrun.
REQ-023 dataReady held high continuously SHALL produce exactly one frame.
REQ-024 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-025 While rst=1, the block SHALL force state=IDLE, txStart=0, txData=0x00, frameDone=0, overrun=0, dRdyQ=0, counters=0 and checksum=0. The sample buffer need not be cleared.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately: no further txStart and no frameDone.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset: rst high 3 cycles -> txStart=0, txData=00, busy=0, frameDone=0, overrun=0.
- Basic frame: sample0=18'h3FFFF, sample1=18'h00001, rest 0; UART model busy 10 cycles per byte -> stream A5, FF FF FF, 00 00 01, 186 x 00, checksum FE. That is 194 txStart pulses, one frameDone, overrun=0.
- Negative extreme: sample0=18'h20000, rest 0 -> bytes 1..3 = FE 00 00, checksum FE.
- Overrun: dataReady drops, then rises again while byte 40 is in flight -> overrun=1, 194-byte stream unchanged, block returns to IDLE with no second frame.
- Abort: rst pulsed during byte 50, then a new edge -> the next frame starts with A5 and sends all 194 bytes.
- Level hold and stall: dataReady held high for 2000 cycles with txBusy stuck high at start -> block waits in ISSUE with no txStart, then sends exactly one frame after txBusy falls.
